bram_fifo_ctrl: RTL
===================

Name: bram_fifo_ctrl

Overview:
- First-word-fall-through FIFO controller that sequences an external simple-dual-port, single-clock BRAM: write port, read port, 1-cycle registered read gated by rden.
- Provides valid/ready stream interfaces on both sides, plus occupancy and almost-full flags.
- Hides the BRAM read latency with a 2-entry output buffer so the stream sustains 1 word/cycle.
- Sits between producer and consumer pipeline stages wherever BRAM-backed buffering is needed.

Parameters:
- C_DATA_WIDTH, 64, word width; equals the attached RAM width.
- C_DEPTH, 512, RAM entries; must be a power of 2 and >= 4.
- C_ALMOST_FULL_THRESH, 480, RAM occupancy at or above which almost_full asserts.

Ports:
- clk  in  1  the only clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear; takes priority over all traffic.
- s_valid  in  1  producer word valid.
- s_ready  out  1  controller accepts the word.
- s_data  in  C_DATA_WIDTH  producer word.
- m_valid  out  1  head word valid.
- m_ready  in  1  consumer takes the head word.
- m_data  out  C_DATA_WIDTH  head word.
- count  out  clog2(C_DEPTH)+2  total words held (RAM + in-flight + output buffer).
- almost_full  out  1  RAM occupancy >= C_ALMOST_FULL_THRESH.
- ram_wrAddr  out  clog2(C_DEPTH)  RAM write address.
- ram_wren  out  1  RAM write enable.
- ram_datain  out  C_DATA_WIDTH  RAM write data.
- ram_rdAddr  out  clog2(C_DEPTH)  RAM read address.
- ram_rden  out  1  RAM read enable.
- ram_dataout  in  C_DATA_WIDTH  RAM registered read data, valid the cycle after ram_rden.

Behaviour:
- Pointers: wr_ptr and rd_ptr are clog2(C_DEPTH)+1 bits, with the MSB as wrap bit. ram_cnt = wr_ptr - rd_ptr. RAM full when ram_cnt == C_DEPTH; empty when ram_cnt == 0.
- Write path:
  - s_ready = !full & !flush & rst_n.
  - push = s_valid & s_ready.
  - ram_wren = push; ram_wrAddr = wr_ptr low bits; ram_datain = s_data (all combinational).
  - wr_ptr increments on push and wraps naturally.
- Read issue:
  - pop = m_valid & m_ready.
  - ram_rden = (ram_cnt != 0) & (ob_cnt + inflight - pop < 2) & !flush.
  - ram_rdAddr = rd_ptr low bits; rd_ptr increments on ram_rden.
  - inflight register <= ram_rden.
  - A word written at edge N is never read before edge N+1, so there is no same-address read/write collision.
- Output buffer (ob): 2-entry register FIFO, ob_cnt 0..2.
  - When inflight = 1, ram_dataout is captured into ob at that edge.
  - Pop and capture in the same cycle are both honoured.
  - m_valid = (ob_cnt != 0); m_data = ob head (registered, no combinational path from ram_dataout).
- Latency: word accepted at edge N is presented with m_valid = 1 after edge N+2 when the FIFO is empty and m_ready is high. Sustained throughput is 1 word/cycle in and out.
- count = ram_cnt + inflight + ob_cnt, updated every edge. almost_full is combinational from ram_cnt.
- Full: push is blocked; ram_rden may still issue in the same cycle, and s_ready rises the cycle after rd_ptr advances.
- Empty: m_valid = 0; m_data holds its last value (don't-care).
- Simultaneous push and pop: both honoured; count unchanged.
- flush (synchronous):
  - Next edge: wr_ptr = rd_ptr = 0, ob_cnt = 0, inflight = 0.
  - Any in-flight RAM return is discarded.
  - ram_wren = ram_rden = 0 and s_ready = 0 during the flush cycle.
- Reset (async, mid-operation allowed): pointers, ob_cnt, inflight and ob storage clear to 0.
  - While rst_n = 0: m_valid = 0, m_data = 0, s_ready = 0, ram_wren = ram_rden = 0, count = 0, almost_full = 0.
  - RAM contents are abandoned, not cleared.

Test Plan:
- Single word: reset, then push 0xA5 at edge N with m_ready = 1 -> m_valid high after edge N+2 with m_data = 0xA5; count goes 1 -> 0 after the pop edge.
- Streaming: 1000 back-to-back words 0..999 with s_valid = m_ready = 1 -> in-order output, no bubbles after the first 2 cycles, s_ready never drops.
- Fill to full: m_ready = 0, push until s_ready = 0 -> exactly C_DEPTH+2 = 514 words accepted, count = 514, almost_full set once ram_cnt reaches 480. Then drain -> 514 words in order, data intact across pointer wrap.
- Simultaneous push/pop at count = 300 for 50 cycles -> count stays 300; rd/wr pointers wrap past 511 correctly.
- Flush with an inflight read and ob_cnt = 2 -> next cycle count = 0, m_valid = 0. The stale RAM return is not captured, and a subsequent push of 0x1 emerges as the first word.
- Assert rst_n = 0 mid-stream for one cycle -> all outputs at reset values immediately (asynchronously). After release, the first pushed word 0x77 is the first word out.

Source files
------------

// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external single-clock simple-dual-port BRAM.
// A 2-entry output buffer hides the 1-cycle BRAM read latency so the stream sustains 1 word/cycle.
module bram_fifo_ctrl #(
  parameter int C_DATA_WIDTH         = 64,
  parameter int C_DEPTH              = 512,
  parameter int C_ALMOST_FULL_THRESH = 480
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [C_DATA_WIDTH-1:0]      s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [C_DATA_WIDTH-1:0]      m_data,
  output logic [$clog2(C_DEPTH)+1:0]   count,
  output logic                         almost_full,
  output logic [$clog2(C_DEPTH)-1:0]   ram_wrAddr,
  output logic                         ram_wren,
  output logic [C_DATA_WIDTH-1:0]      ram_datain,
  output logic [$clog2(C_DEPTH)-1:0]   ram_rdAddr,
  output logic                         ram_rden,
  input  logic [C_DATA_WIDTH-1:0]      ram_dataout
);

  localparam int AW = $clog2(C_DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(C_DEPTH);
  localparam logic [AW:0] AF_V    = (AW+1)'(C_ALMOST_FULL_THRESH);

  logic [AW:0]             wrPtr_q, wrPtr_d;
  logic [AW:0]             rdPtr_q, rdPtr_d;
  logic                    inflight_q, inflight_d;
  logic [1:0]              obCnt_q, obCnt_d;
  logic [C_DATA_WIDTH-1:0] ob0_q, ob0_d;
  logic [C_DATA_WIDTH-1:0] ob1_q, ob1_d;

  logic [AW:0] ramCnt;
  logic        full;
  logic        push;
  logic        pop;
  logic [2:0]  obPending;
  logic [1:0]  obSlot;

  assign ramCnt      = wrPtr_q - rdPtr_q;
  assign full        = (ramCnt == DEPTH_V);
  assign almost_full = rst_n & (ramCnt >= AF_V);

  assign s_ready = ~full & ~flush & rst_n;
  assign push    = s_valid & s_ready;
  assign m_valid = (obCnt_q != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = ob0_q;

  // Only fetch when the buffer plus the word already in flight leaves room after this cycle's pop.
  assign obPending = {1'b0, obCnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign ram_rden  = (ramCnt != '0) & (obPending < 3'd2) & ~flush & rst_n;

  assign ram_wren   = push;
  assign ram_wrAddr = wrPtr_q[AW-1:0];
  assign ram_datain = s_data;
  assign ram_rdAddr = rdPtr_q[AW-1:0];

  assign count = {1'b0, ramCnt} + (AW+2)'(inflight_q) + (AW+2)'(obCnt_q);

  // Returning RAM data lands in the first free slot after this cycle's pop has shifted the buffer.
  assign obSlot = obCnt_q - {1'b0, pop};

  always_comb begin
    wrPtr_d    = wrPtr_q + (AW+1)'(push);
    rdPtr_d    = rdPtr_q + (AW+1)'(ram_rden);
    inflight_d = ram_rden;
    ob0_d      = ob0_q;
    ob1_d      = ob1_q;
    obCnt_d    = obCnt_q + {1'b0, inflight_q} - {1'b0, pop};

    if (pop) begin
      ob0_d = ob1_q;
    end
    if (inflight_q) begin
      if (obSlot == 2'd0) begin
        ob0_d = ram_dataout;
      end else begin
        ob1_d = ram_dataout;
      end
    end

    if (flush) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      inflight_d = 1'b0;
      obCnt_d    = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      inflight_q <= 1'b0;
      obCnt_q    <= 2'd0;
      ob0_q      <= '0;
      ob1_q      <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      inflight_q <= inflight_d;
      obCnt_q    <= obCnt_d;
      ob0_q      <= ob0_d;
      ob1_q      <= ob1_d;
    end
  end

endmodule
